// File: rtl/sram_req_arbiter_if.sv
// Sram-like request/response bus shared by the CPU requesters and the bridge.
// master drives the request payload; slave returns accept, response and read data.
interface sram_req_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-into-one sram port arbiter: data has default priority, inst is forced
// after STARVE_MAX back-to-back data grants, and a presented request is held
// until it is accepted. A tag FIFO routes in-order responses to their owner.
//
// Grant lock states:
//   state        | meaning
//   GS_FREE      | no request pending on the bus, selection is open
//   GS_LOCK_INST | inst request presented but not yet accepted, inst held
//   GS_LOCK_DATA | data request presented but not yet accepted, data held
module sram_req_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                     clk,
   input  logic                     resetn,
   sram_req_arbiter_if.slave        inst,
   sram_req_arbiter_if.slave        data,
   sram_req_arbiter_if.master       out,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     err_orphan
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      GS_FREE      = 2'd0,
      GS_LOCK_INST = 2'd1,
      GS_LOCK_DATA = 2'd2
   } grant_state_t;

   grant_state_t     gs;
   grant_state_t     gs_nxt;
   logic             sel_data;
   logic             sel_req;
   logic             full;
   logic             empty;
   logic             accept;
   logic             pop;
   logic             head_tag;
   logic [DEPTH-1:0] tag_mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [SW-1:0]    starve_cnt;

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign outstanding = count;

   // Pick the requester that owns the bus this cycle.
   always_comb begin
      sel_data = 1'b0;
      case (gs)
         GS_LOCK_INST: sel_data = 1'b0;
         GS_LOCK_DATA: sel_data = 1'b1;
         default: begin
            if (data.req && inst.req && (starve_cnt == SW'(STARVE_MAX)))
               sel_data = 1'b0;
            else if (data.req)
               sel_data = 1'b1;
            else
               sel_data = 1'b0;
         end
      endcase
   end

   assign sel_req   = sel_data ? data.req : inst.req;
   // Full uses the registered count only, so a pop frees a slot one cycle later.
   assign out.req   = resetn & sel_req & ~full;
   assign out.wr    = sel_data ? data.wr    : inst.wr;
   assign out.size  = sel_data ? data.size  : inst.size;
   assign out.wstrb = sel_data ? data.wstrb : inst.wstrb;
   assign out.addr  = sel_data ? data.addr  : inst.addr;
   assign out.wdata = sel_data ? data.wdata : inst.wdata;

   assign accept       = out.req & out.addr_ok;
   assign inst.addr_ok = accept & ~sel_data;
   assign data.addr_ok = accept & sel_data;

   assign pop           = resetn & out.data_ok & ~empty;
   assign head_tag      = tag_mem[rd_ptr];
   assign inst.data_ok  = pop & ~head_tag;
   assign data.data_ok  = pop & head_tag;
   assign inst.rdata    = out.rdata;
   assign data.rdata    = out.rdata;

   // Grant lock next state: hold an unaccepted request, release on accept or drop.
   always_comb begin
      gs_nxt = gs;
      if (accept)
         gs_nxt = GS_FREE;
      else if (out.req)
         gs_nxt = sel_data ? GS_LOCK_DATA : GS_LOCK_INST;
      else if ((gs != GS_FREE) && !sel_req)
         gs_nxt = GS_FREE;
   end

   // Grant lock state register.
   always_ff @(posedge clk) begin
      if (!resetn) gs <= GS_FREE;
      else         gs <= gs_nxt;
   end

   // Count data grants made while inst waits; any inst grant or idle inst clears it.
   always_ff @(posedge clk) begin
      if (!resetn)
         starve_cnt <= '0;
      else if (!inst.req || (accept && !sel_data))
         starve_cnt <= '0;
      else if (accept && sel_data && (starve_cnt != SW'(STARVE_MAX)))
         starve_cnt <= starve_cnt + SW'(1);
   end

   // Tag storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (accept) tag_mem[wr_ptr] <= sel_data;
   end

   // Tag FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A response with nothing outstanding is flagged until the next reset.
   always_ff @(posedge clk) begin
      if (!resetn)                  err_orphan <= 1'b0;
      else if (out.data_ok && empty) err_orphan <= 1'b1;
   end

endmodule
